// File: rtl/noc_local_inject_arb.sv
// Packet-level round-robin arbiter for the tile NoC local injection port.
// Holds each grant from a packet's first beat to its TLAST and truncates over-length packets.
module noc_local_inject_arb #(
  parameter int NREQ      = 3,
  parameter int BW        = 32,
  parameter int BWB       = 4,
  parameter int MAX_BEATS = 64
) (
  input  logic                     clk_line,
  input  logic                     clk_line_rst_low,
  input  logic [NREQ-1:0]          req_en,
  input  logic [NREQ-1:0]          in_TVALID,
  input  logic [NREQ*BW-1:0]       in_TDATA,
  input  logic [NREQ*BWB-1:0]      in_TKEEP,
  input  logic [NREQ-1:0]          in_TLAST,
  output logic [NREQ-1:0]          in_TREADY,
  output logic                     out_TVALID,
  output logic [BW-1:0]            out_TDATA,
  output logic [BWB-1:0]           out_TKEEP,
  output logic                     out_TLAST,
  input  logic                     out_TREADY,
  input  logic                     err_clr,
  output logic [NREQ-1:0]          err_overlen,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [15:0]              pkt_cnt
);

  localparam int GW = $clog2(NREQ);
  localparam int SW = GW + 1;
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, LOCK, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_cnt;
  logic            load;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] rot;
  logic [SW-1:0]   sh;
  logic [SW-1:0]   sum;
  logic [GW-1:0]   pick;
  logic            pick_ok;
  logic [NREQ-1:0] gsel;
  logic [BW-1:0]   cur_data;
  logic [BWB-1:0]  cur_keep;
  logic            cur_vld;
  logic            cur_last;
  logic            beat;
  logic            force_last;

  // Valid/ready: a transfer happens on any rising edge where valid and ready are both high;
  // valid, once raised, holds its payload until that edge. in_TREADY never depends on in_TVALID.
  assign load = !out_TVALID || out_TREADY;
  assign cand = in_TVALID & req_en;
  assign busy = (state_q != IDLE);

  // Rotate candidates so bit 0 is the requester after the last grant.
  assign sh  = {1'b0, grant_id} + SW'(1);
  assign rot = NREQ'({cand, cand} >> sh);

  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    sum     = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!pick_ok && rot[j]) begin
        pick_ok = 1'b1;
        sum     = sh + SW'(j);
        if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
        pick    = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    gsel     = '0;
    cur_data = '0;
    cur_keep = '0;
    cur_vld  = 1'b0;
    cur_last = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_id == GW'(j)) begin
        gsel[j]  = 1'b1;
        cur_data = in_TDATA[j*BW +: BW];
        cur_keep = in_TKEEP[j*BWB +: BWB];
        cur_vld  = in_TVALID[j];
        cur_last = in_TLAST[j];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    in_TREADY  = '0;
    beat       = 1'b0;
    force_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_ok) state_d = LOCK;
      end
      LOCK: begin
        in_TREADY = gsel & {NREQ{load}};
        beat      = cur_vld && load;
        if (beat) begin
          if (cur_last) begin
            state_d = IDLE;
          end else if (beat_cnt == CW'(MAX_BEATS - 1)) begin
            force_last = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Tail of a truncated packet is swallowed, never emitted.
        in_TREADY = gsel;
        if (cur_vld && cur_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      state_q     <= IDLE;
      grant_id    <= GW'(NREQ - 1);
      beat_cnt    <= '0;
      out_TVALID  <= 1'b0;
      out_TDATA   <= '0;
      out_TKEEP   <= '0;
      out_TLAST   <= 1'b0;
      err_overlen <= '0;
      pkt_cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_ok) grant_id <= pick;

      if (state_q != IDLE && state_d == IDLE) beat_cnt <= '0;
      else if (beat) beat_cnt <= beat_cnt + CW'(1);

      if (beat) begin
        out_TVALID <= 1'b1;
        out_TDATA  <= cur_data;
        out_TKEEP  <= cur_keep;
        out_TLAST  <= cur_last || force_last;
      end else if (out_TREADY) begin
        out_TVALID <= 1'b0;
      end

      // A new error in the same cycle as a clear survives.
      err_overlen <= (err_clr ? '0 : err_overlen) | (force_last ? gsel : '0);

      if (out_TVALID && out_TREADY && out_TLAST && pkt_cnt != 16'hFFFF)
        pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_noc_local_inject_arb.sv
// Bench for noc_local_inject_arb: random packets per requester, expected output stream
// built from a packet-level round-robin model.
module tb_noc_local_inject_arb;

  localparam int NREQ = 3;
  localparam int BW   = 32;
  localparam int BWB  = 4;
  localparam int MB   = 4;
  localparam int GW   = 2;
  localparam int EW   = BW + BWB + 1;

  logic                clk_line = 1'b0;
  logic                clk_line_rst_low;
  logic [NREQ-1:0]     req_en;
  logic [NREQ-1:0]     in_TVALID;
  logic [NREQ*BW-1:0]  in_TDATA;
  logic [NREQ*BWB-1:0] in_TKEEP;
  logic [NREQ-1:0]     in_TLAST;
  logic [NREQ-1:0]     in_TREADY;
  logic                out_TVALID;
  logic [BW-1:0]       out_TDATA;
  logic [BWB-1:0]      out_TKEEP;
  logic                out_TLAST;
  logic                out_TREADY;
  logic                err_clr;
  logic [NREQ-1:0]     err_overlen;
  logic [GW-1:0]       grant_id;
  logic                busy;
  logic [15:0]         pkt_cnt;

  always #5 clk_line = ~clk_line;

  noc_local_inject_arb #(.NREQ(NREQ), .BW(BW), .BWB(BWB), .MAX_BEATS(MB)) dut (
    .clk_line(clk_line), .clk_line_rst_low(clk_line_rst_low), .req_en(req_en),
    .in_TVALID(in_TVALID), .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP), .in_TLAST(in_TLAST),
    .in_TREADY(in_TREADY), .out_TVALID(out_TVALID), .out_TDATA(out_TDATA),
    .out_TKEEP(out_TKEEP), .out_TLAST(out_TLAST), .out_TREADY(out_TREADY),
    .err_clr(err_clr), .err_overlen(err_overlen), .grant_id(grant_id), .busy(busy),
    .pkt_cnt(pkt_cnt)
  );

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [EW-1:0]   src_q[NREQ][$];
  int              lens_q[NREQ][$];
  logic [EW-1:0]   exp_q[$];
  int              m_last;
  int              exp_pkts;
  logic [NREQ-1:0] exp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Build each requester's packets, then the output stream the arbiter should produce.
  task automatic gen_and_model(input logic [NREQ-1:0] en, input int np_lo, input int np_hi,
                               input int len_lo, input int len_hi);
    int pk[NREQ];
    int ptr[NREQ];
    int np, len, n, j, c;
    logic [EW-1:0] e;
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      lens_q[i].delete();
      pk[i]  = 0;
      ptr[i] = 0;
      np = $urandom_range(np_lo, np_hi);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(len_lo, len_hi);
        lens_q[i].push_back(len);
        for (int b = 0; b < len; b++) begin
          e = {BW'($urandom()), BWB'($urandom_range(1, 15)), (b == len - 1)};
          src_q[i].push_back(e);
        end
      end
    end
    while (1) begin
      j = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (j < 0 && en[c] && pk[c] < lens_q[c].size()) j = c;
      end
      if (j < 0) break;
      len = lens_q[j][pk[j]];
      n = (len > MB) ? MB : len;
      for (int b = 0; b < n; b++) begin
        e = src_q[j][ptr[j] + b];
        e[0] = (b == n - 1);
        exp_q.push_back(e);
      end
      if (len > MB) exp_err[j] = 1'b1;
      ptr[j] += len;
      pk[j]++;
      exp_pkts++;
      m_last = j;
    end
  endtask

  // ready_mode: 0 always ready, 1 toggling 1010, 2 random. Entered at posedge+1.
  task automatic run_scen(input logic [NREQ-1:0] en, input int np_lo, input int np_hi,
                          input int len_lo, input int len_hi, input int ready_mode,
                          input int en_off_cyc, input int abort_cyc);
    logic [NREQ-1:0] hs;
    bit first[NREQ];
    int cyc;
    bit done;
    gen_and_model(en, np_lo, np_hi, len_lo, len_hi);
    req_en = en;
    hs = '0;
    in_TVALID = '0;
    for (int i = 0; i < NREQ; i++) first[i] = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 2000 && !(abort_cyc > 0 && cyc >= abort_cyc)) begin
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          first[i] = src_q[i][0][0];
          void'(src_q[i].pop_front());
          in_TVALID[i] = 1'b0;
        end
        if (!in_TVALID[i] && src_q[i].size() > 0 && (first[i] || $urandom_range(0, 3) != 0)) begin
          in_TDATA[i*BW +: BW]   = src_q[i][0][EW-1 -: BW];
          in_TKEEP[i*BWB +: BWB] = src_q[i][0][BWB:1];
          in_TLAST[i]            = src_q[i][0][0];
          in_TVALID[i]           = 1'b1;
        end
      end
      case (ready_mode)
        0:       out_TREADY = 1'b1;
        1:       out_TREADY = (cyc % 2 == 0);
        default: out_TREADY = ($urandom_range(0, 2) != 0);
      endcase
      if (cyc == en_off_cyc) req_en = '0;
      @(negedge clk_line);
      hs = in_TVALID & in_TREADY;
      if (out_TVALID && out_TREADY) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat", {out_TDATA, out_TKEEP, out_TLAST}, exp_q.pop_front());
      end
      cyc++;
      done = (exp_q.size() == 0);
      for (int i = 0; i < NREQ; i++)
        if (en[i] && !(src_q[i].size() == 0 || (src_q[i].size() == 1 && hs[i]))) done = 1'b0;
      @(posedge clk_line);
      #1;
    end
    if (abort_cyc > 0 && !done) return;
    if (!done) check("timeout", 0, 1);
    in_TVALID  = '0;
    out_TREADY = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    repeat (2) @(posedge clk_line);
    #1;
    check("end_valid", out_TVALID, 0);
    check("end_busy", busy, 0);
    check("pkt_cnt", pkt_cnt, exp_pkts);
    check("err_overlen", err_overlen, exp_err);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk_line);
    #1;
    err_clr = 1'b0;
    exp_err = '0;
    check("err_clr", err_overlen, 0);
  endtask

  initial begin
    clk_line_rst_low = 1'b0;
    req_en = '0; in_TVALID = '0; in_TDATA = '0; in_TKEEP = '0; in_TLAST = '0;
    out_TREADY = 1'b1; err_clr = 1'b0;
    m_last = NREQ - 1; exp_pkts = 0; exp_err = '0;
    repeat (3) @(posedge clk_line);
    #1;
    check("rst_valid", out_TVALID, 0);
    check("rst_data", {out_TDATA, out_TKEEP, out_TLAST}, 0);
    check("rst_ready", in_TREADY, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_err", err_overlen, 0);
    check("rst_grant", grant_id, NREQ - 1);
    check("rst_busy", busy, 0);
    #2 clk_line_rst_low = 1'b1;
    @(posedge clk_line);
    #1;

    run_scen(3'b111, 1, 2, 4, 4, 0, -1, 0);   // round robin from requester 0
    run_scen(3'b010, 1, 1, 4, 4, 1, -1, 0);   // toggling backpressure
    run_scen(3'b100, 1, 1, 6, 6, 0, -1, 0);   // over-length truncation and drain
    clear_err();
    run_scen(3'b001, 1, 1, 4, 4, 2, -1, 0);   // exact MAX_BEATS, no error
    run_scen(3'b010, 1, 1, 4, 4, 0, 3, 0);    // req_en dropped mid-packet
    for (int s = 0; s < 10; s++)
      run_scen(3'($urandom_range(1, 7)), 1, 3, 1, 6, 2, -1, 0);
    clear_err();

    // Async reset in the middle of a packet.
    run_scen(3'b111, 1, 1, 6, 6, 0, -1, 4);
    check("busy_mid", busy, 1);
    #2 clk_line_rst_low = 1'b0;
    #1;
    check("arst_valid", out_TVALID, 0);
    check("arst_ready", in_TREADY, 0);
    check("arst_pkt_cnt", pkt_cnt, 0);
    check("arst_busy", busy, 0);
    check("arst_grant", grant_id, NREQ - 1);
    in_TVALID = '0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    m_last = NREQ - 1; exp_pkts = 0; exp_err = '0;
    @(posedge clk_line);
    #3 clk_line_rst_low = 1'b1;
    @(posedge clk_line);
    #1;
    run_scen(3'b111, 1, 2, 1, 6, 2, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
